fifo_uart_tx: RTL and testbench

Downstream drain stage for the 8-bit message FIFO in the master/slave PicoBlaze link. It pops bytes from the FIFO whenever the FIFO is non-empty and the block is enabled. Each byte is serialized onto a UART line as 8 data bits, LSB first, with optional even parity and one stop bit. It is the FIFO's only reader and drives the FIFO `rd` input directly.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_baud_gen.sv | 44 ++++
 rtl/fifo_uart_tx.sv | 137 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared constants and state encoding for the FIFO-drain UART TX.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DATA_BITS            = 8;
  localparam int BIT_IDX_W            = $clog2(DATA_BITS);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_POP    = 3'd1;
  localparam logic [2:0] ST_LATCH  = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_PARITY = 3'd5;
  localparam logic [2:0] ST_STOP   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_POP    = ST_POP,
    S_LATCH  = ST_LATCH,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } state_e;

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ============================================================================
// Module   : uart_baud_gen
// Brief    : Clear-on-load bit-period counter; bit_end_o marks the last cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic bit_end_o
);

  localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_end_o = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || bit_end_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_uart_tx.sv
// ============================================================================
// Module   : fifo_uart_tx
// Brief    : Drains the message FIFO and serialises each byte as a UART frame.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        rd,
  output logic        txd,
  output logic        busy,
  output logic        tx_done,
  output logic [15:0] frame_cnt
);

  state_e                 state_q, state_d;
  logic [7:0]             shift_q, shift_d;
  logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic                   parity_q, parity_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic                   rd_q;
  logic                   txd_q, txd_d;
  logic                   bit_end;
  logic                   start_ok;

  assign start_ok = en && !fifo_empty;

  // Every state change restarts the bit period.
  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_d != state_q),
    .bit_end_o (bit_end)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    parity_d    = parity_q;
    frame_cnt_d = frame_cnt_q;
    tx_done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) state_d = S_POP;
      end
      S_POP: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        shift_d  = fifo_data;
        parity_d = ^fifo_data;
        state_d  = S_START;
      end
      S_START: begin
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          tx_done     = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = start_ok ? S_POP : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line level is computed from the next state so txd leaves a flop.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
      S_PARITY: txd_d = parity_d;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      parity_q    <= 1'b0;
      frame_cnt_q <= '0;
      rd_q        <= 1'b0;
      txd_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      parity_q    <= parity_d;
      frame_cnt_q <= frame_cnt_d;
      rd_q        <= (state_d == S_POP);
      txd_q       <= txd_d;
    end
  end

  assign rd        = rd_q;
  assign txd       = txd_q;
  assign busy      = (state_q != S_IDLE);
  assign frame_cnt = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
// ============================================================================
// Module   : tb_fifo_uart_tx
// Brief    : Directed bench for fifo_uart_tx with 4 clocks per bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [7:0]  fifo_data   = 8'h00;
  logic [7:0]  p_fifo_data = 8'h00;
  logic        fifo_empty, p_fifo_empty;
  logic        rd, txd, busy, tx_done;
  logic        p_rd, p_txd, p_busy, p_tx_done;
  logic [15:0] frame_cnt, p_frame_cnt;

  logic [7:0]  mem   [16];
  logic [7:0]  p_mem [16];
  int wr_ptr = 0, rd_ptr = 0, p_wr_ptr = 0, p_rd_ptr = 0;
  int checks = 0, errors = 0, cyc = 0, rd_total = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .rd(rd), .txd(txd), .busy(busy), .tx_done(tx_done), .frame_cnt(frame_cnt)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dut_p (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(p_fifo_empty), .fifo_data(p_fifo_data),
    .rd(p_rd), .txd(p_txd), .busy(p_busy), .tx_done(p_tx_done), .frame_cnt(p_frame_cnt)
  );

  // FIFO models: read data appears the cycle after rd is sampled.
  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign p_fifo_empty = (p_wr_ptr == p_rd_ptr);

  always @(posedge clk) begin
    if (rd) begin
      fifo_data <= mem[rd_ptr % 16];
      rd_ptr    <= rd_ptr + 1;
    end
    if (p_rd) begin
      p_fifo_data <= p_mem[p_rd_ptr % 16];
      p_rd_ptr    <= p_rd_ptr + 1;
    end
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (rd) rd_total++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 16] = b;
    wr_ptr++;
  endtask

  task automatic p_push(input logic [7:0] b);
    p_mem[p_wr_ptr % 16] = b;
    p_wr_ptr++;
  endtask

  // {rd, txd, busy, tx_done} of the selected instance
  function automatic logic [3:0] sig(input bit p);
    return p ? {p_rd, p_txd, p_busy, p_tx_done} : {rd, txd, busy, tx_done};
  endfunction

  task automatic wait_rd(input bit p, input string tag);
    logic [3:0] v;
    v = sig(p);
    for (int i = 0; i < 20 && !v[3]; i++) begin
      tick();
      v = sig(p);
    end
    check(tag, {31'd0, v[3]}, 32'd1);
  endtask

  // Called in the POP cycle (cycle 0); follows the frame to its last stop cycle.
  task automatic watch_frame(input string tag, input bit p, input int nbits, input logic [11:0] exp_bits);
    logic [3:0] v;
    logic [3:0] s;
    int rd_n, busy_lo, done_cyc;
    rd_n = 0; busy_lo = 0; done_cyc = -1;
    v = sig(p);
    if (!v[1]) busy_lo++;
    tick();
    v = sig(p);
    if (v[3]) rd_n++;
    if (!v[1]) busy_lo++;
    check($sformatf("%s_txd_latch", tag), {31'd0, v[2]}, 32'd1);
    for (int b = 0; b < nbits; b++) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        v = sig(p);
        s[k] = v[2];
        if (v[3]) rd_n++;
        if (!v[1]) busy_lo++;
        if (v[0]) done_cyc = (done_cyc < 0) ? (2 + 4 * b + k) : 999;
      end
      check($sformatf("%s_bit%0d", tag, b), {28'd0, s}, {28'd0, {4{exp_bits[b]}}});
    end
    check($sformatf("%s_rd_in_frame", tag), rd_n, 0);
    check($sformatf("%s_busy_low", tag), busy_lo, 0);
    check($sformatf("%s_done_cycle", tag), done_cyc, 2 + 4 * nbits - 1);
  endtask

  initial begin
    int a, b, c, t1, t2, r0;

    // Reset values
    rst = 1'b0;
    en  = 1'b0;
    repeat (2) tick();
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_rd", {31'd0, rd}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, tx_done}, 32'd0);
    check("rst_cnt", {16'd0, frame_cnt}, 32'd0);
    rst = 1'b1;
    repeat (2) tick();

    // Empty FIFO with en high: nothing happens
    en = 1'b1;
    a = 0; b = 0; c = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (rd) a++;
      if (!txd) b++;
      if (busy) c++;
    end
    check("s4_rd", a, 0);
    check("s4_txd_low", b, 0);
    check("s4_busy", c, 0);

    // Single byte 0x55, no parity
    push(8'h55);
    wait_rd(1'b0, "s1_rd");
    watch_frame("s1", 1'b0, 10, {2'b00, 1'b1, 8'h55, 1'b0});
    tick();
    check("s1_busy_after", {31'd0, busy}, 32'd0);
    check("s1_cnt", {16'd0, frame_cnt}, 32'd1);
    check("s1_rd_count", rd_total, 1);

    // Parity instance, byte 0xA7: parity bit is 1
    p_push(8'hA7);
    wait_rd(1'b1, "s2_rd");
    watch_frame("s2", 1'b1, 11, {1'b0, 1'b1, 1'b1, 8'hA7, 1'b0});
    tick();
    check("s2_cnt", {16'd0, p_frame_cnt}, 32'd1);
    check("s2_busy_after", {31'd0, p_busy}, 32'd0);

    // Idle reset pulse clears the frame counter
    rst = 1'b0;
    tick();
    check("s3_pre_cnt", {16'd0, frame_cnt}, 32'd0);
    rst = 1'b1;
    tick();

    // Back-to-back 0x01, 0x80
    r0 = rd_total;
    push(8'h01);
    push(8'h80);
    wait_rd(1'b0, "s3_rd1");
    t1 = cyc;
    watch_frame("s3a", 1'b0, 10, {2'b00, 1'b1, 8'h01, 1'b0});
    tick();
    check("s3_rd2", {31'd0, rd}, 32'd1);
    t2 = cyc;
    watch_frame("s3b", 1'b0, 10, {2'b00, 1'b1, 8'h80, 1'b0});
    tick();
    check("s3_cnt", {16'd0, frame_cnt}, 32'd2);
    check("s3_spacing", t2 - t1, 42);
    repeat (5) tick();
    check("s3_rd_count", rd_total - r0, 2);

    // en dropped during data bit 3 with two bytes queued
    push(8'h3C);
    push(8'hC3);
    wait_rd(1'b0, "s5_rd1");
    a = -1;
    for (int i = 1; i <= 41; i++) begin
      tick();
      if (i == 19) en = 1'b0;
      if (tx_done) a = i;
    end
    check("s5_done", a, 41);
    b = 0; c = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rd) b++;
      if (busy) c++;
    end
    check("s5_no_rd", b, 0);
    check("s5_busy", c, 0);
    check("s5_cnt", {16'd0, frame_cnt}, 32'd3);
    en = 1'b1;
    wait_rd(1'b0, "s5_rd2");
    watch_frame("s5b", 1'b0, 10, {2'b00, 1'b1, 8'hC3, 1'b0});
    tick();
    check("s5_cnt2", {16'd0, frame_cnt}, 32'd4);

    // Reset mid-frame during data bit 3 of 0x96 (a zero bit)
    push(8'h96);
    push(8'h5A);
    wait_rd(1'b0, "s6_rd1");
    repeat (20) tick();
    check("s6_busy_pre", {31'd0, busy}, 32'd1);
    check("s6_txd_pre", {31'd0, txd}, 32'd0);
    rst = 1'b0;
    #1;
    check("s6_txd_rst", {31'd0, txd}, 32'd1);
    check("s6_busy_rst", {31'd0, busy}, 32'd0);
    check("s6_cnt_rst", {16'd0, frame_cnt}, 32'd0);
    tick();
    rst = 1'b1;
    wait_rd(1'b0, "s6_rd2");
    watch_frame("s6b", 1'b0, 10, {2'b00, 1'b1, 8'h5A, 1'b0});
    tick();
    check("s6_cnt", {16'd0, frame_cnt}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
